// File: rtl/regfile_checker.sv
// Register-file signature checker: waits for a completion signature, then scans the register
// file against a golden table. Optional mismatch log FIFO built when REGFILE_CHECKER_LOG_EN is set.
module regfile_checker #(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    NREG      = 32,
  parameter int unsigned    SIG_REG   = 11,
  parameter logic [XLEN-1:0] SIG_VAL  = 'h0000C0DE,
  parameter int unsigned    TIMEOUT   = 1000,
  parameter int unsigned    LOG_DEPTH = 4,
  localparam int unsigned   AW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] sig_rdata,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            gold_we,
  input  logic [AW-1:0]   gold_waddr,
  input  logic [XLEN-1:0] gold_wdata,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [AW:0]     err_count,
  output logic [AW-1:0]   first_err_idx,
  output logic [XLEN-1:0] first_err_got,
  output logic            log_valid,
  input  logic            log_ready,
  output logic [AW-1:0]   log_idx,
  output logic [XLEN-1:0] log_got,
  output logic            log_ovf
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StScan = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_q, timeout_d;
  logic [AW:0]     err_q, err_d;
  logic [AW-1:0]   ferr_idx_q, ferr_idx_d;
  logic [XLEN-1:0] ferr_got_q, ferr_got_d;

  logic [XLEN-1:0] gold_q [NREG];

  logic idle_or_done;
  logic arm;
  logic mismatch;

  // The signature register index is carried for documentation/integration only.
  logic [AW-1:0] unused_sig_reg;
  assign unused_sig_reg = AW'(SIG_REG);

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign arm          = start && idle_or_done;
  assign mismatch     = (state_q == StScan) && (rf_rdata !== gold_q[idx_q]);

  // Golden table is not reset; it is only writable while no run is in flight.
  always_ff @(posedge clk) begin
    if (gold_we && idle_or_done && (32'(gold_waddr) < NREG)) begin
      gold_q[gold_waddr] <= gold_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    ferr_idx_d = ferr_idx_q;
    ferr_got_d = ferr_got_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWait;
          idx_d      = '0;
          timer_d    = '0;
          timeout_d  = 1'b0;
          err_d      = '0;
          ferr_idx_d = '0;
          ferr_got_d = '0;
        end
      end
      StWait: begin
        // A signature match in the final timer cycle wins over the timeout.
        if (sig_rdata == SIG_VAL) begin
          state_d = StScan;
          idx_d   = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = StScan;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StScan: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            ferr_idx_d = idx_q;
            ferr_got_d = rf_rdata;
          end
        end
        if (idx_q == AW'(NREG - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      ferr_idx_q <= '0;
      ferr_got_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_got_q <= ferr_got_d;
    end
  end

  assign busy          = (state_q == StWait) || (state_q == StScan);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_q == '0) && !timeout_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_idx_q;
  assign first_err_got = ferr_got_q;
  assign rf_raddr      = (state_q == StScan) ? idx_q : '0;

`ifdef REGFILE_CHECKER_LOG_EN
  localparam int unsigned PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [AW+XLEN-1:0] log_mem_q [LOG_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pop, full, push_ok;

  assign pop     = (cnt_q != '0) && log_ready;
  assign full    = (cnt_q == (PW+1)'(LOG_DEPTH));
  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  assign push_ok = mismatch && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      log_mem_q[wr_ptr_q] <= {idx_q, rf_rdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(LOG_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PW'(LOG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (mismatch && !push_ok) begin
        ovf_d = 1'b1;
      end
      cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign log_valid          = (cnt_q != '0);
  assign {log_idx, log_got} = log_mem_q[rd_ptr_q];
  assign log_ovf            = ovf_q;
`else
  logic unused_log_ready;
  logic unused_log_arm;
  assign unused_log_ready = log_ready;
  assign unused_log_arm   = arm;
  assign log_valid        = 1'b0;
  assign log_idx          = '0;
  assign log_got          = '0;
  assign log_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// Directed self-checking bench for regfile_checker (TIMEOUT=10, NREG=32, LOG_DEPTH=4).
module tb_regfile_checker;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam logic [XLEN-1:0] SIG = 32'h0000C0DE;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [XLEN-1:0] sig_rdata;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            gold_we;
  logic [AW-1:0]   gold_waddr;
  logic [XLEN-1:0] gold_wdata;
  logic            busy, done, pass, timeout;
  logic [AW:0]     err_count;
  logic [AW-1:0]   first_err_idx;
  logic [XLEN-1:0] first_err_got;
  logic            log_valid, log_ready, log_ovf;
  logic [AW-1:0]   log_idx;
  logic [XLEN-1:0] log_got;

  logic [XLEN-1:0] rf   [NREG];
  logic [XLEN-1:0] gold [NREG];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  regfile_checker #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .SIG_REG  (11),
    .SIG_VAL  (SIG),
    .TIMEOUT  (10),
    .LOG_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .sig_rdata    (sig_rdata),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .gold_we      (gold_we),
    .gold_waddr   (gold_waddr),
    .gold_wdata   (gold_wdata),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .first_err_got(first_err_got),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_idx      (log_idx),
    .log_got      (log_got),
    .log_ovf      (log_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_gold();
    for (int i = 0; i < NREG; i++) begin
      gold_we    = 1'b1;
      gold_waddr = AW'(i);
      gold_wdata = gold[i];
      step();
    end
    gold_we = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic rf_restore();
    for (int i = 0; i < NREG; i++) rf[i] = gold[i];
  endtask

  int n;

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    sig_rdata  = '0;
    gold_we    = 1'b0;
    gold_waddr = '0;
    gold_wdata = '0;
    log_ready  = 1'b0;
    for (int i = 0; i < NREG; i++) gold[i] = 32'h1000_0000 + 32'(i * 7);
    rf_restore();
    step();
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_raddr", rf_raddr, 0);
    check_eq("rst_logv", log_valid, 0);
    reset_n = 1'b1;
    step();
    load_gold();

    // Clean run, signature appears on the third WAIT_SIG cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t1_busy", busy, 1);
    check_eq("t1_raddr_wait", rf_raddr, 0);
    step();
    step();
    sig_rdata = SIG;
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
      if (n == 6) check_eq("t1_raddr_scan", rf_raddr, 5);
    end
    check_eq("t1_latency", n, NREG + 1);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_err", err_count, 0);
    check_eq("t1_timeout", timeout, 0);
    check_eq("t1_busy_done", busy, 0);

    // Two mismatches, immediate signature match.
    gold[5] = 32'h5;
    load_gold();
    rf[5]  = 32'h6;
    rf[20] = gold[20] ^ 32'h1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, n);
    check_eq("t2_latency", n, NREG + 2);
    check_eq("t2_err", err_count, 2);
    check_eq("t2_fidx", first_err_idx, 5);
    check_eq("t2_fgot", first_err_got, 32'h6);
    check_eq("t2_pass", pass, 0);
`ifdef REGFILE_CHECKER_LOG_EN
    check_eq("t2_log0_v", log_valid, 1);
    check_eq("t2_log0_idx", log_idx, 5);
    check_eq("t2_log0_got", log_got, 32'h6);
    log_ready = 1'b1;
    step();
    check_eq("t2_log1_idx", log_idx, 20);
    check_eq("t2_log1_got", log_got, gold[20] ^ 32'h1);
    step();
    log_ready = 1'b0;
    check_eq("t2_log_empty", log_valid, 0);
`else
    check_eq("t2_log_tied", log_valid, 0);
`endif

    // Timeout run, with an ignored start and an ignored golden write mid-run.
    rf_restore();
    sig_rdata = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t3_no_restart_busy", busy, 1);
    repeat (5) step();
    check_eq("t3_to_before", timeout, 0);
    check_eq("t3_raddr_wait", rf_raddr, 0);
    step();
    check_eq("t3_to_set", timeout, 1);
    check_eq("t3_busy_scan", busy, 1);
    gold_we    = 1'b1;
    gold_waddr = AW'(31);
    gold_wdata = 32'hDEAD_BEEF;
    step();
    gold_we = 1'b0;
    wait_done(1, n);
    check_eq("t3_latency", n, NREG);
    check_eq("t3_err", err_count, 0);
    check_eq("t3_pass", pass, 0);
    check_eq("t3_timeout", timeout, 1);

    // Six mismatches against a four-entry log that is never drained.
    sig_rdata = SIG;
    rf[1] = gold[1] ^ 32'hF0;
    rf[2] = gold[2] ^ 32'hF0;
    rf[3] = gold[3] ^ 32'hF0;
    rf[4] = gold[4] ^ 32'hF0;
    rf[8] = gold[8] ^ 32'hF0;
    rf[9] = gold[9] ^ 32'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, n);
    check_eq("t4_err", err_count, 6);
    check_eq("t4_fidx", first_err_idx, 1);
    check_eq("t4_timeout", timeout, 0);
`ifdef REGFILE_CHECKER_LOG_EN
    check_eq("t4_ovf", log_ovf, 1);
    log_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("t4_log_v", log_valid, 1);
      check_eq("t4_log_idx", log_idx, AW'(k));
      check_eq("t4_log_got", log_got, gold[k] ^ 32'hF0);
      step();
    end
    log_ready = 1'b0;
    check_eq("t4_log_empty", log_valid, 0);
`else
    check_eq("t4_ovf_tied", log_ovf, 0);
    check_eq("t4_logv_tied", log_valid, 0);
`endif

    // Asynchronous reset in the middle of a scan, then a clean run.
    rf_restore();
    rf[2] = gold[2] ^ 32'h100;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (rf_raddr != AW'(7) && n < 200) begin
      step();
      n++;
    end
    check_eq("t5_reach_idx7", rf_raddr, 7);
    check_eq("t5_err_pre", err_count, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    check_eq("t5_pass", pass, 0);
    check_eq("t5_timeout", timeout, 0);
    check_eq("t5_err", err_count, 0);
    check_eq("t5_fidx", first_err_idx, 0);
    check_eq("t5_fgot", first_err_got, 0);
    check_eq("t5_raddr", rf_raddr, 0);
    check_eq("t5_logv", log_valid, 0);
    check_eq("t5_ovf", log_ovf, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    rf_restore();
    load_gold();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, n);
    check_eq("t6_latency", n, NREG + 2);
    check_eq("t6_pass", pass, 1);
    check_eq("t6_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_checker.md
REGFILE_CHECKER -- requirements
Module: regfile_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of registers scanned (2..64).
REQ-003 SHALL have parameter SIG_REG, default 11, register index carrying the completion signature.
REQ-004 SHALL have parameter SIG_VAL, default 32'h0000C0DE, completion signature value.
REQ-005 SHALL have parameter TIMEOUT, default 1000, maximum cycles waited for the signature (>=1).
REQ-006 SHALL have parameter LOG_DEPTH, default 4, mismatch log entries (power of 2).
REQ-007 SHALL have local AW = clog2(NREG).
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  one-cycle pulse that arms a check run.
REQ-011 sig_rdata  in  XLEN  live value of register SIG_REG.
REQ-012 rf_raddr  out  AW  scan read address into the register file.
REQ-013 rf_rdata  in  XLEN  combinational register file data for rf_raddr.
REQ-014 gold_we / gold_waddr / gold_wdata  in  1 / AW / XLEN  golden table write port.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  run complete; results valid.
REQ-017 pass  out  1  err_count==0 and timeout==0, valid while done.
REQ-018 timeout  out  1  signature not seen within TIMEOUT cycles.
REQ-019 err_count  out  AW+1  number of mismatching registers.
REQ-020 first_err_idx / first_err_got  out  AW / XLEN  first mismatching index and its actual value.
REQ-021 log_valid / log_ready / log_idx / log_got / log_ovf  out/in/out/out/out  1/1/AW/XLEN/1  mismatch log pop port.

Function
REQ-022 SHALL hold an internal NREG x XLEN golden table written on gold_we in IDLE or DONE only; writes in other states are ignored.
REQ-023 SHALL implement states IDLE, WAIT_SIG, SCAN, DONE.
REQ-024 IDLE/DONE + start: next cycle WAIT_SIG; clear timer, timeout, err_count, first_err_*, log contents, log_ovf; done=0, busy=1.
REQ-025 start in WAIT_SIG or SCAN SHALL be ignored.
REQ-026 WAIT_SIG: if sig_rdata==SIG_VAL, next state SCAN with index 0; the timer increments every cycle otherwise.
REQ-027 WAIT_SIG: when timer reaches TIMEOUT-1 with no match, set timeout=1 and enter SCAN (registers still compared); a match in that same cycle takes priority and leaves timeout=0.
REQ-028 SCAN: rf_raddr=index; each cycle compare rf_rdata against golden[index] with 4-state-equivalent exact equality (any bit difference is a mismatch).
REQ-029 On a mismatch: err_count+1; if it is the first, capture index and rf_rdata into first_err_*; push {index, rf_rdata} into the log.
REQ-030 SCAN SHALL take exactly NREG cycles; after index NREG-1 enter DONE (done=1, busy=0) the following cycle.
REQ-031 rf_raddr SHALL be 0 outside SCAN.
REQ-032 Total latency from the signature match to done = NREG+1 cycles; from start with an immediate match = NREG+2.
REQ-033 Log: FIFO, pop when log_valid&&log_ready; push when full with a simultaneous pop SHALL succeed; push when full without pop SHALL drop the entry and set sticky log_ovf.
REQ-034 Results SHALL hold in DONE until the next start.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_idx=0, first_err_got=0, rf_raddr=0, log empty, log_ovf=0.
REQ-036 Reset mid-run SHALL abort the run; golden table contents need not be preserved.

Configuration
REQ-037 Macro REGFILE_CHECKER_LOG_EN: when defined, the mismatch log of REQ-033 is built.
REQ-038 Without REGFILE_CHECKER_LOG_EN, the log ports SHALL remain present, log_valid/log_idx/log_got/log_ovf tied 0, log_ready ignored; all other behaviour unchanged.

Verification
REQ-039 Golden = rf contents, sig_rdata=0xC0DE on cycle 3 after start -> done after NREG+1 cycles, pass=1, err_count=0, timeout=0.
REQ-040 Golden x5=0x5, rf x5=0x6, x20 mismatched too -> err_count=2, first_err_idx=5, first_err_got=0x6, pass=0; with LOG_EN, log pops (5,0x6) then (20,...).
REQ-041 TIMEOUT=10, sig never matches -> timeout=1 at cycle 10 of WAIT_SIG, scan still runs, pass=0 even with err_count=0.
REQ-042 LOG_DEPTH=4, 6 mismatches, log_ready=0 -> 4 entries retained in order, log_ovf=1, err_count=6.
REQ-043 reset_n low in mid-SCAN at index 7 -> all outputs 0 asynchronously; new start after release -> full clean run, pass=1.
REQ-044 gold_we during SCAN altering x31 -> ignored; start pulse during WAIT_SIG -> no restart, timer continues.
